// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory channel arbiter.
//   state_t     : per-channel FSM state
//   owner_bits  : width of a consumer index (at least 1 bit)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } state_t;

  localparam int unsigned PERF_BITS = 32;

  function automatic int unsigned owner_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_channel_arbiter_if.sv
// Cache-side and memory-side handshake bundle of the memory channel arbiter.
//   slave  : arbiter view (takes consumer requests, issues memory requests)
//   master : environment view (cache consumers plus global memory)
interface mem_channel_arbiter_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CONSUMERS = 4,
  parameter int unsigned CHANNELS  = 1
);

  logic [CONSUMERS-1:0]           consumer_read_valid;
  logic [CONSUMERS*ADDR_BITS-1:0] consumer_read_addr;
  logic [CONSUMERS-1:0]           consumer_read_ready;
  logic [CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [CONSUMERS-1:0]           consumer_write_valid;
  logic [CONSUMERS*ADDR_BITS-1:0] consumer_write_addr;
  logic [CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [CONSUMERS-1:0]           consumer_write_ready;

  logic [CHANNELS-1:0]            mem_read_valid;
  logic [CHANNELS*ADDR_BITS-1:0]  mem_read_addr;
  logic [CHANNELS-1:0]            mem_read_ready;
  logic [CHANNELS*DATA_BITS-1:0]  mem_read_data;
  logic [CHANNELS-1:0]            mem_write_valid;
  logic [CHANNELS*ADDR_BITS-1:0]  mem_write_addr;
  logic [CHANNELS*DATA_BITS-1:0]  mem_write_data;
  logic [CHANNELS-1:0]            mem_write_ready;

  modport slave (
    input  consumer_read_valid, consumer_read_addr,
    output consumer_read_ready, consumer_read_data,
    input  consumer_write_valid, consumer_write_addr, consumer_write_data,
    output consumer_write_ready,
    output mem_read_valid, mem_read_addr,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_addr, mem_write_data,
    input  mem_write_ready
  );

  modport master (
    output consumer_read_valid, consumer_read_addr,
    input  consumer_read_ready, consumer_read_data,
    output consumer_write_valid, consumer_write_addr, consumer_write_data,
    input  consumer_write_ready,
    input  mem_read_valid, mem_read_addr,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_addr, mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: first requesting, non-excluded index
// scanning upward from ptr with wrap.
//   req     : request mask
//   excl    : excluded (already claimed) mask
//   ptr     : scan start index
//   found_c : some index qualified
//   index_c : the chosen index
module mem_arb_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  excl,
  input  logic [PW-1:0] ptr,
  output logic          found_c,
  output logic [PW-1:0] index_c
);

  logic [PW-1:0] idx;

  // Scan from the far end back toward ptr so the closest candidate wins last.
  always_comb begin
    found_c = 1'b0;
    index_c = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((32'(ptr) + 32'(k)) % N);
      if (req[idx] && !excl[idx]) begin
        found_c = 1'b1;
        index_c = idx;
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Multiplexes CONSUMERS cache-side request ports onto CHANNELS memory ports.
// Each channel runs its own IDLE/READ_WAIT/WRITE_WAIT/RELAY FSM; grants are
// round-robin and every output is registered.
//   clk, reset (async, active-low)
//   bus   : mem_channel_arbiter_if.slave (consumer and memory handshakes)
//   perf_grants, perf_stall_cycles : present only with MEM_ARB_PERF_EN
module mem_channel_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CONSUMERS = 4,
  parameter int unsigned CHANNELS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_channel_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_BITS-1:0]  perf_grants,
  output logic [PERF_BITS-1:0]  perf_stall_cycles
`endif
);

  localparam int unsigned OB = owner_bits(CONSUMERS);

  state_t                         state_q [CHANNELS];
  state_t                         state_d [CHANNELS];
  logic [OB-1:0]                  owner_q [CHANNELS];
  logic [OB-1:0]                  owner_d [CHANNELS];
  logic [CONSUMERS-1:0]           claimed_q, claimed_d;
  logic [OB-1:0]                  rr_ptr_q, rr_ptr_d;

  logic [CHANNELS-1:0]            mrv_d, mwv_d;
  logic [CHANNELS*ADDR_BITS-1:0]  mra_d, mwa_d;
  logic [CHANNELS*DATA_BITS-1:0]  mwd_d;
  logic [CONSUMERS-1:0]           crr_d, cwr_d;
  logic [CONSUMERS*DATA_BITS-1:0] crd_d;

  logic [CONSUMERS-1:0]           req_c;
  logic [CHANNELS-1:0]            grant_c;
  logic [OB-1:0]                  pick_c [CHANNELS];
  logic [CONSUMERS-1:0]           taken_c;

  assign req_c = bus.consumer_read_valid | bus.consumer_write_valid;

  // Pickers chained in ascending channel order; a consumer granted by a lower
  // channel this cycle is excluded from every higher one.
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_pick
    logic [CONSUMERS-1:0] excl_in, excl_out;
    logic                 found;
    logic [OB-1:0]        idx;

    if (ch == 0) begin : g_first
      assign excl_in = claimed_q;
    end else begin : g_next
      assign excl_in = g_pick[ch-1].excl_out;
    end

    mem_arb_rr_pick #(.N(CONSUMERS), .PW(OB)) u_pick (
      .req     (req_c),
      .excl    (excl_in),
      .ptr     (rr_ptr_q),
      .found_c (found),
      .index_c (idx)
    );

    assign grant_c[ch] = found && (state_q[ch] == IDLE);
    assign pick_c[ch]  = idx;
    assign excl_out    = excl_in | (grant_c[ch] ? (CONSUMERS'(1) << idx) : '0);
  end

  // Consumers newly granted by any channel this cycle.
  assign taken_c = g_pick[CHANNELS-1].excl_out & ~claimed_q;

  // Next-state and next-output logic for all channels.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    claimed_d = claimed_q | taken_c;
    rr_ptr_d  = rr_ptr_q;
    mrv_d     = bus.mem_read_valid;
    mra_d     = bus.mem_read_addr;
    mwv_d     = bus.mem_write_valid;
    mwa_d     = bus.mem_write_addr;
    mwd_d     = bus.mem_write_data;
    crr_d     = bus.consumer_read_ready;
    crd_d     = bus.consumer_read_data;
    cwr_d     = bus.consumer_write_ready;

    for (int ch = 0; ch < CHANNELS; ch++) begin
      case (state_q[ch])
        IDLE: begin
          if (grant_c[ch]) begin
            owner_d[ch] = pick_c[ch];
            // Read wins; a pending write of the same consumer waits for a later grant.
            if (bus.consumer_read_valid[pick_c[ch]]) begin
              mrv_d[ch] = 1'b1;
              mra_d[ch*ADDR_BITS +: ADDR_BITS] =
                bus.consumer_read_addr[pick_c[ch]*ADDR_BITS +: ADDR_BITS];
              state_d[ch] = READ_WAIT;
            end else begin
              mwv_d[ch] = 1'b1;
              mwa_d[ch*ADDR_BITS +: ADDR_BITS] =
                bus.consumer_write_addr[pick_c[ch]*ADDR_BITS +: ADDR_BITS];
              mwd_d[ch*DATA_BITS +: DATA_BITS] =
                bus.consumer_write_data[pick_c[ch]*DATA_BITS +: DATA_BITS];
              state_d[ch] = WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (bus.mem_read_ready[ch]) begin
            mrv_d[ch]          = 1'b0;
            crr_d[owner_q[ch]] = 1'b1;
            crd_d[owner_q[ch]*DATA_BITS +: DATA_BITS] =
              bus.mem_read_data[ch*DATA_BITS +: DATA_BITS];
            state_d[ch] = RELAY;
          end
        end
        WRITE_WAIT: begin
          if (bus.mem_write_ready[ch]) begin
            mwv_d[ch]          = 1'b0;
            cwr_d[owner_q[ch]] = 1'b1;
            state_d[ch]        = RELAY;
          end
        end
        RELAY: begin
          // Release once the owner drops the valid matching the ready we raised.
          if (bus.consumer_read_ready[owner_q[ch]] ? !bus.consumer_read_valid[owner_q[ch]]
                                                   : !bus.consumer_write_valid[owner_q[ch]]) begin
            crr_d[owner_q[ch]]     = 1'b0;
            cwr_d[owner_q[ch]]     = 1'b0;
            claimed_d[owner_q[ch]] = 1'b0;
            rr_ptr_d = (32'(owner_q[ch]) == CONSUMERS - 1) ? '0 : owner_q[ch] + OB'(1);
            state_d[ch] = IDLE;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        owner_q[ch] <= '0;
      end
      claimed_q                <= '0;
      rr_ptr_q                 <= '0;
      bus.mem_read_valid       <= '0;
      bus.mem_read_addr        <= '0;
      bus.mem_write_valid      <= '0;
      bus.mem_write_addr       <= '0;
      bus.mem_write_data       <= '0;
      bus.consumer_read_ready  <= '0;
      bus.consumer_read_data   <= '0;
      bus.consumer_write_ready <= '0;
    end else begin
      state_q                  <= state_d;
      owner_q                  <= owner_d;
      claimed_q                <= claimed_d;
      rr_ptr_q                 <= rr_ptr_d;
      bus.mem_read_valid       <= mrv_d;
      bus.mem_read_addr        <= mra_d;
      bus.mem_write_valid      <= mwv_d;
      bus.mem_write_addr       <= mwa_d;
      bus.mem_write_data       <= mwd_d;
      bus.consumer_read_ready  <= crr_d;
      bus.consumer_read_data   <= crd_d;
      bus.consumer_write_ready <= cwr_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic any_idle_c;

  always_comb begin
    any_idle_c = 1'b0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (state_q[ch] == IDLE) any_idle_c = 1'b1;
    end
  end

  // Grant count and cycles where unclaimed work waits with no free channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_grants       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_grants <= perf_grants + PERF_BITS'($countones(grant_c));
      if (((req_c & ~claimed_q) != '0) && !any_idle_c)
        perf_stall_cycles <= perf_stall_cycles + PERF_BITS'(1);
    end
  end
`endif

endmodule
